// File: rtl/video_frame_scheduler.sv
// video_frame_scheduler: sequences frame starts to a video source, with a per-frame watchdog,
// pixel/line size checking and an inter-frame gap.
module video_frame_scheduler #(
  parameter int FRAME_GAP = 16,
  parameter int TIMEOUT   = 700000,
  parameter int EXP_H     = 800,
  parameter int EXP_V     = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] num_frames,
  output logic       src_begin,
  input  logic       src_done,
  input  logic       src_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt,
  output logic       err_timeout,
  output logic       err_size
);
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, FIN} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int TO_LAST = TIMEOUT > 1 ? TIMEOUT - 2 : 0;
  state_t state, next;
  logic [WW-1:0] wd;
  logic [15:0] gap_cnt, pix, line, line_inc;
  logic [7:0] num_lat, fc_inc;
  logic prev_valid, fall, to_hit, fin_cnt;
  always_comb begin
    fall = state == RUN && prev_valid && !src_valid;
    fc_inc = frame_cnt + 8'd1;
    line_inc = (line == '1) ? line : line + 16'd1;
    to_hit = wd == WW'(TO_LAST);
    fin_cnt = num_lat != 8'd0 && fc_inc == num_lat;
    next = state;
    case (state)
      IDLE:    next = start ? LAUNCH : IDLE;
      LAUNCH:  next = abort ? FIN : RUN;
      RUN:     next = src_done ? ((abort || fin_cnt) ? FIN : GAP) : ((abort || to_hit) ? FIN : RUN);
      GAP:     next = abort ? FIN : (gap_cnt == 16'(FRAME_GAP - 1)) ? LAUNCH : GAP;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      src_begin <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      frame_cnt <= '0;
      err_timeout <= 1'b0;
      err_size <= 1'b0;
      num_lat <= '0;
      wd <= '0;
      gap_cnt <= '0;
      pix <= '0;
      line <= '0;
      prev_valid <= 1'b0;
    end else begin
      state <= next;
      src_begin <= next == LAUNCH;
      busy <= next != IDLE;
      done <= state == FIN;
      prev_valid <= state == RUN && src_valid;
      gap_cnt <= state == GAP ? gap_cnt + 16'd1 : 16'd0;
      if (state == IDLE && start) begin
        num_lat <= num_frames;
        frame_cnt <= '0;
        err_timeout <= 1'b0;
        err_size <= 1'b0;
      end
      if (state == LAUNCH) begin
        wd <= '0;
        pix <= '0;
        line <= '0;
      end
      if (state == RUN) begin
        wd <= wd + 1'b1;
        if (src_valid && pix != '1) pix <= pix + 16'd1;
        if (fall) begin
          pix <= '0;
          line <= line_inc;
          if (pix != 16'(EXP_H)) err_size <= 1'b1;
        end
        // a line closing in the same cycle as src_done still counts toward the frame
        if (src_done) begin
          frame_cnt <= fc_inc;
          if ((fall ? line_inc : line) != 16'(EXP_V)) err_size <= 1'b1;
        end else if (to_hit) err_timeout <= 1'b1;
      end
    end
  end
endmodule
